demux32_1_2_buf: RTL and testbench

Buffered 32-bit 1-to-2 stream demultiplexer, the steering counterpart of the datapath's 2:1 select muxes. It accepts one word per cycle on a valid/ready input and routes it, by a per-word select bit, into one of two independent 2-entry FIFOs. Each FIFO drains through its own valid/ready output port. It sits between a producer stage and two consumer paths (e.g. ALU result vs. memory write port), decoupling their stalls.

---
 rtl/demux32_1_2_buf_if.sv | 35 +++
 rtl/demux32_1_2_buf.sv | 127 ++++++++++++
 tb/tb_demux32_1_2_buf.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux32_1_2_buf_if.sv
// Stream bundle for the buffered 1-to-2 demux: one valid/ready input with a
// destination select, two valid/ready output ports and their delivery counters.
interface demux32_1_2_buf_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;

    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic [CNT_W-1:0] a_count;

    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic [CNT_W-1:0] b_count;

    // Producer / consumer side: drives the input stream and both readies.
    modport master (
        output in_valid, in_data, in_sel, a_ready, b_ready,
        input  in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
    );

    // Demux side.
    modport slave (
        input  in_valid, in_data, in_sel, a_ready, b_ready,
        output in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
    );

endinterface

// File: rtl/demux32_1_2_buf.sv
// Buffered 1-to-2 stream demux: each accepted word is steered by in_sel into
// one of two 2-entry FIFOs, each drained through its own valid/ready port.
module demux32_1_2_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    demux32_1_2_buf_if.slave bus
);

    localparam int unsigned OCC_W    = 2;
    localparam int unsigned DEPTH    = 2;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // FIFO A state
    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_a_d [DEPTH];
    logic             wr_ptr_a_q, wr_ptr_a_d;
    logic             rd_ptr_a_q, rd_ptr_a_d;
    logic [OCC_W-1:0] occ_a_q, occ_a_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;

    // FIFO B state
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [WIDTH-1:0] mem_b_d [DEPTH];
    logic             wr_ptr_b_q, wr_ptr_b_d;
    logic             rd_ptr_b_q, rd_ptr_b_d;
    logic [OCC_W-1:0] occ_b_q, occ_b_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    logic in_ready_c;
    logic push_a_c, push_b_c;
    logic pop_a_c,  pop_b_c;

    // Ready looks only at the selected FIFO's registered fill level, so a pop
    // in the same cycle never frees space for a push.
    always_comb begin
        in_ready_c = bus.in_sel ? (occ_b_q != OCC_FULL) : (occ_a_q != OCC_FULL);
        push_a_c   = bus.in_valid & in_ready_c & ~bus.in_sel;
        push_b_c   = bus.in_valid & in_ready_c &  bus.in_sel;
        pop_a_c    = (occ_a_q != '0) & bus.a_ready;
        pop_b_c    = (occ_b_q != '0) & bus.b_ready;
    end

    // FIFO A next state
    always_comb begin
        mem_a_d    = mem_a_q;
        wr_ptr_a_d = wr_ptr_a_q;
        rd_ptr_a_d = rd_ptr_a_q;
        occ_a_d    = occ_a_q;
        cnt_a_d    = cnt_a_q;
        if (push_a_c) begin
            mem_a_d[wr_ptr_a_q] = bus.in_data;
            wr_ptr_a_d          = ~wr_ptr_a_q;
        end
        if (pop_a_c) begin
            rd_ptr_a_d = ~rd_ptr_a_q;
            cnt_a_d    = cnt_a_q + CNT_W'(1);
        end
        if (push_a_c && !pop_a_c) begin
            occ_a_d = occ_a_q + OCC_W'(1);
        end else if (!push_a_c && pop_a_c) begin
            occ_a_d = occ_a_q - OCC_W'(1);
        end
    end

    // FIFO B next state
    always_comb begin
        mem_b_d    = mem_b_q;
        wr_ptr_b_d = wr_ptr_b_q;
        rd_ptr_b_d = rd_ptr_b_q;
        occ_b_d    = occ_b_q;
        cnt_b_d    = cnt_b_q;
        if (push_b_c) begin
            mem_b_d[wr_ptr_b_q] = bus.in_data;
            wr_ptr_b_d          = ~wr_ptr_b_q;
        end
        if (pop_b_c) begin
            rd_ptr_b_d = ~rd_ptr_b_q;
            cnt_b_d    = cnt_b_q + CNT_W'(1);
        end
        if (push_b_c && !pop_b_c) begin
            occ_b_d = occ_b_q + OCC_W'(1);
        end else if (!push_b_c && pop_b_c) begin
            occ_b_d = occ_b_q - OCC_W'(1);
        end
    end

    // Control state: cleared asynchronously, discarding anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_a_q <= 1'b0;
            rd_ptr_a_q <= 1'b0;
            occ_a_q    <= '0;
            cnt_a_q    <= '0;
            wr_ptr_b_q <= 1'b0;
            rd_ptr_b_q <= 1'b0;
            occ_b_q    <= '0;
            cnt_b_q    <= '0;
        end else begin
            wr_ptr_a_q <= wr_ptr_a_d;
            rd_ptr_a_q <= rd_ptr_a_d;
            occ_a_q    <= occ_a_d;
            cnt_a_q    <= cnt_a_d;
            wr_ptr_b_q <= wr_ptr_b_d;
            rd_ptr_b_q <= rd_ptr_b_d;
            occ_b_q    <= occ_b_d;
            cnt_b_q    <= cnt_b_d;
        end
    end

    // Storage carries no reset; it is only observed when the matching valid is set.
    always_ff @(posedge clk) begin
        mem_a_q <= mem_a_d;
        mem_b_q <= mem_b_d;
    end

    assign bus.in_ready = in_ready_c;
    assign bus.a_valid  = (occ_a_q != '0);
    assign bus.a_data   = mem_a_q[rd_ptr_a_q];
    assign bus.a_count  = cnt_a_q;
    assign bus.b_valid  = (occ_b_q != '0);
    assign bus.b_data   = mem_b_q[rd_ptr_b_q];
    assign bus.b_count  = cnt_b_q;

endmodule

// File: tb/tb_demux32_1_2_buf.sv
// Directed bench for demux32_1_2_buf: routing, backpressure, wrap, counter
// wrap and asynchronous reset, each scenario checked against hand-computed values.
module tb_demux32_1_2_buf;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    logic [31:0] got_a[$];
    logic [31:0] got_b[$];

    demux32_1_2_buf_if #(.WIDTH(32), .CNT_W(16)) ifc ();

    demux32_1_2_buf #(.WIDTH(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records words that will be popped at the coming edge, then advances to
    // 1 time unit after that edge where inputs are driven and outputs sampled.
    task automatic tick();
        if (ifc.a_valid === 1'b1 && ifc.a_ready === 1'b1) got_a.push_back(ifc.a_data);
        if (ifc.b_valid === 1'b1 && ifc.b_ready === 1'b1) got_b.push_back(ifc.b_data);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_sel   = 1'b0;
        ifc.in_data  = 32'h5555_5555;
        ifc.a_ready  = 1'b0;
        ifc.b_ready  = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ifc.a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_push_blocked: a_valid=%0b want 0", ifc.a_valid); end
        n_checks++;
        if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", ifc.in_ready); end
        n_checks++;
        if (ifc.a_count !== 16'h0 || ifc.b_count !== 16'h0) begin
            n_fail++; $display("FAIL rst_counts: a=%h b=%h want 0 0", ifc.a_count, ifc.b_count);
        end
        ifc.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (ifc.a_valid !== 1'b0 || ifc.b_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_%0d: a_valid=%0b b_valid=%0b in_ready=%0b want 0 0 1",
                         i, ifc.a_valid, ifc.b_valid, ifc.in_ready);
            end
            n_checks++;
            if (ifc.a_count !== 16'h0 || ifc.b_count !== 16'h0) begin
                n_fail++; $display("FAIL idle_counts_%0d: a=%h b=%h want 0 0", i, ifc.a_count, ifc.b_count);
            end
        end
    endtask

    task automatic test_alternate();
        got_a.delete();
        got_b.delete();
        ifc.a_ready = 1'b1;
        ifc.b_ready = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_sel = 1'b0; ifc.in_data = 32'h1111_1111; tick();
        ifc.in_sel = 1'b1; ifc.in_data = 32'h2222_2222; tick();
        ifc.in_sel = 1'b0; ifc.in_data = 32'h3333_3333; tick();
        ifc.in_valid = 1'b0;
        tick(); tick();
        n_checks++;
        if (got_a.size() != 2 || got_a[0] !== 32'h1111_1111 || got_a[1] !== 32'h3333_3333) begin
            n_fail++; $display("FAIL alt_a_seq: size=%0d first=%h want 2 words 11111111,33333333",
                               got_a.size(), (got_a.size() > 0) ? got_a[0] : 32'hx);
        end
        n_checks++;
        if (got_b.size() != 1 || got_b[0] !== 32'h2222_2222) begin
            n_fail++; $display("FAIL alt_b_seq: size=%0d want 1 word 22222222", got_b.size());
        end
        n_checks++;
        if (ifc.a_count !== 16'd2 || ifc.b_count !== 16'd1) begin
            n_fail++; $display("FAIL alt_counts: a=%0d b=%0d want 2 1", ifc.a_count, ifc.b_count);
        end
    endtask

    task automatic test_full();
        got_a.delete();
        got_b.delete();
        ifc.a_ready  = 1'b0;
        ifc.b_ready  = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_sel   = 1'b0;
        ifc.in_data  = 32'hA0;
        n_checks++;
        if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_rdy_a0: got %0b want 1", ifc.in_ready); end
        tick();
        ifc.in_data = 32'hA1;
        n_checks++;
        if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_rdy_a1: got %0b want 1", ifc.in_ready); end
        tick();
        ifc.in_data = 32'hA2;
        n_checks++;
        if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_rdy_a2: got %0b want 0", ifc.in_ready); end
        tick();
        n_checks++;
        if (ifc.in_ready !== 1'b0 || ifc.a_valid !== 1'b1 || ifc.a_data !== 32'hA0) begin
            n_fail++; $display("FAIL full_hold: in_ready=%0b a_valid=%0b a_data=%h want 0 1 000000a0",
                               ifc.in_ready, ifc.a_valid, ifc.a_data);
        end
        ifc.in_sel  = 1'b1;
        ifc.in_data = 32'hB0;
        #1;
        n_checks++;
        if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_rdy_b0: got %0b want 1", ifc.in_ready); end
        tick();
        n_checks++;
        if (ifc.b_valid !== 1'b1 || ifc.b_data !== 32'hB0) begin
            n_fail++; $display("FAIL full_b0: b_valid=%0b b_data=%h want 1 000000b0", ifc.b_valid, ifc.b_data);
        end
        ifc.in_sel  = 1'b0;
        ifc.in_data = 32'hA2;
        ifc.a_ready = 1'b1;
        #1;
        n_checks++;
        if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_rdy_indep: got %0b want 0", ifc.in_ready); end
        tick();
        tick();
        ifc.in_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (got_a.size() != 3 || got_a[0] !== 32'hA0 || got_a[1] !== 32'hA1 || got_a[2] !== 32'hA2) begin
            n_fail++; $display("FAIL full_a_order: size=%0d want 3 words a0,a1,a2", got_a.size());
        end
        ifc.b_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (got_b.size() != 1 || got_b[0] !== 32'hB0) begin
            n_fail++; $display("FAIL full_b_drain: size=%0d want 1 word b0", got_b.size());
        end
        n_checks++;
        if (ifc.a_count !== 16'd5 || ifc.b_count !== 16'd2) begin
            n_fail++; $display("FAIL full_counts: a=%0d b=%0d want 5 2", ifc.a_count, ifc.b_count);
        end
    endtask

    task automatic test_simul_wrap();
        logic [31:0] exp_a [6];
        bit ok;
        got_a.delete();
        ifc.a_ready  = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_sel   = 1'b0;
        ifc.in_data  = 32'h0FF;
        tick();
        ifc.a_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ifc.in_data = 32'h100 + 32'(i);
            #1;
            n_checks++;
            if (ifc.in_ready !== 1'b1 || ifc.a_valid !== 1'b1) begin
                n_fail++; $display("FAIL sim_occ_%0d: in_ready=%0b a_valid=%0b want 1 1", i, ifc.in_ready, ifc.a_valid);
            end
            tick();
        end
        ifc.in_valid = 1'b0;
        ifc.a_ready  = 1'b0;
        #1;
        n_checks++;
        if (ifc.a_valid !== 1'b1 || ifc.a_data !== 32'h105) begin
            n_fail++; $display("FAIL sim_residual: a_valid=%0b a_data=%h want 1 00000105", ifc.a_valid, ifc.a_data);
        end
        exp_a[0] = 32'h0FF;
        for (int i = 1; i < 6; i++) exp_a[i] = 32'h100 + 32'(i - 1);
        ok = (got_a.size() == 6);
        for (int i = 0; i < 6 && ok; i++) if (got_a[i] !== exp_a[i]) ok = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL sim_seq: size=%0d want ff,100..104", got_a.size()); end
        ifc.a_ready = 1'b1;
        tick();
        ifc.a_ready = 1'b0;
        n_checks++;
        if (ifc.a_valid !== 1'b0 || ifc.a_count !== 16'd12) begin
            n_fail++; $display("FAIL sim_drain: a_valid=%0b a_count=%0d want 0 12", ifc.a_valid, ifc.a_count);
        end
    endtask

    task automatic test_counter_wrap();
        logic [15:0] prev;
        bit seen_wrap;
        seen_wrap = 1'b0;
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        prev = ifc.a_count;
        ifc.a_ready  = 1'b1;
        ifc.b_ready  = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_sel   = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            ifc.in_data = 32'(i);
            tick();
            if (prev == 16'hFFFF && ifc.a_count == 16'h0000) seen_wrap = 1'b1;
            prev = ifc.a_count;
        end
        ifc.in_valid = 1'b0;
        tick();
        got_a.delete();
        got_b.delete();
        n_checks++;
        if (!seen_wrap) begin n_fail++; $display("FAIL cnt_wrap_seen: got 0 want 1"); end
        n_checks++;
        if (ifc.a_count !== 16'h0001) begin n_fail++; $display("FAIL cnt_final: a_count=%h want 0001", ifc.a_count); end
        n_checks++;
        if (ifc.b_count !== 16'h0000) begin n_fail++; $display("FAIL cnt_b_idle: b_count=%h want 0000", ifc.b_count); end
    endtask

    task automatic test_reset_mid();
        ifc.a_ready  = 1'b0;
        ifc.b_ready  = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_sel = 1'b0; ifc.in_data = 32'hC1; tick();
        ifc.in_data = 32'hC2; tick();
        ifc.in_sel = 1'b1; ifc.in_data = 32'hD1; tick();
        ifc.in_data = 32'hD2; tick();
        ifc.in_valid = 1'b0;
        n_checks++;
        if (ifc.a_valid !== 1'b1 || ifc.b_valid !== 1'b1 || ifc.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_full: a_valid=%0b b_valid=%0b in_ready=%0b want 1 1 0",
                               ifc.a_valid, ifc.b_valid, ifc.in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ifc.a_valid !== 1'b0 || ifc.b_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: a_valid=%0b b_valid=%0b want 0 0", ifc.a_valid, ifc.b_valid);
        end
        n_checks++;
        if (ifc.a_count !== 16'h0 || ifc.b_count !== 16'h0 || ifc.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_counts: a=%h b=%h in_ready=%0b want 0 0 1",
                               ifc.a_count, ifc.b_count, ifc.in_ready);
        end
        #1 rst_n = 1'b1;
        tick();
        ifc.in_valid = 1'b1;
        ifc.in_sel   = 1'b1;
        ifc.in_data  = 32'hDEAD_BEEF;
        tick();
        ifc.in_valid = 1'b0;
        n_checks++;
        if (ifc.b_valid !== 1'b1 || ifc.b_data !== 32'hDEAD_BEEF || ifc.a_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_first_b: b_valid=%0b b_data=%h a_valid=%0b want 1 deadbeef 0",
                               ifc.b_valid, ifc.b_data, ifc.a_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_alternate();
        test_full();
        test_simul_wrap();
        test_counter_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
